nor_cmd_sequencer: RTL and testbench

// Sequences JEDEC command cycles (word program, sector erase, chip erase, read-array reset) onto the
// NOR flash via a Wishbone master port into the NOR bus controller, then polls RY/BY# to completion.

---
 rtl/nor_cmd_sequencer_if.sv | 38 +++
 rtl/nor_cmd_sequencer.sv | 186 ++++++++++++++++++
 tb/tb_nor_cmd_sequencer.sv | 470 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/nor_cmd_sequencer_if.sv
// Request/status and Wishbone-write bundle of the NOR command sequencer.
// The slave modport is the sequencer's own view; master is the client/bus-controller side.
interface nor_cmd_sequencer_if #(
    parameter int ADDRBITS  = 26,
    parameter int DATABITS  = 16,
    parameter int TIMEOUT_W = 24
);
    logic                 req_valid_i;
    logic                 req_ready_o;
    logic [1:0]           req_op_i;
    logic [ADDRBITS-1:0]  req_addr_i;
    logic [DATABITS-1:0]  req_data_i;
    logic [TIMEOUT_W-1:0] cfg_timeout_i;
    logic                 busy_o;
    logic                 done_o;
    logic [1:0]           status_o;
    logic                 wb_cyc_o;
    logic                 wb_stb_o;
    logic                 wb_we_o;
    logic [ADDRBITS-1:0]  wb_adr_o;
    logic [DATABITS-1:0]  wb_dat_o;
    logic                 wb_ack_i;
    logic                 nor_ry_i;

    modport slave (
        input  req_valid_i, req_op_i, req_addr_i, req_data_i, cfg_timeout_i,
        input  wb_ack_i, nor_ry_i,
        output req_ready_o, busy_o, done_o, status_o,
        output wb_cyc_o, wb_stb_o, wb_we_o, wb_adr_o, wb_dat_o
    );

    modport master (
        output req_valid_i, req_op_i, req_addr_i, req_data_i, cfg_timeout_i,
        output wb_ack_i, nor_ry_i,
        input  req_ready_o, busy_o, done_o, status_o,
        input  wb_cyc_o, wb_stb_o, wb_we_o, wb_adr_o, wb_dat_o
    );
endinterface

// File: rtl/nor_cmd_sequencer.sv
// Issues JEDEC program/erase/reset command writes to the NOR bus controller over Wishbone,
// then waits on the synchronised RY/BY# pin (with optional busy timeout) and reports status.
module nor_cmd_sequencer #(
    parameter int ADDRBITS  = 26,
    parameter int DATABITS  = 16,
    parameter int TIMEOUT_W = 24,
    parameter int BLANK_CYC = 4
) (
    input logic                clk_i,
    input logic                reset_ni,
    nor_cmd_sequencer_if.slave bus
);
    localparam logic [1:0] OP_PROG = 2'b00;
    localparam logic [1:0] OP_SECT = 2'b01;
    localparam logic [1:0] OP_RST  = 2'b11;
    localparam int BLANK_W = (BLANK_CYC > 1) ? $clog2(BLANK_CYC) : 1;
    localparam int CMD_W   = ADDRBITS + DATABITS;

    typedef enum logic [2:0] {S_IDLE, S_WR, S_GAP, S_BLANK, S_POLL, S_DONE} state_t;

    state_t               state;
    logic [1:0]           op_r;
    logic [ADDRBITS-1:0]  addr_r;
    logic [DATABITS-1:0]  data_r;
    logic [2:0]           idx;
    logic                 abort;
    logic [TIMEOUT_W-1:0] tcnt;
    logic [BLANK_W-1:0]   bcnt;
    logic                 ry_p0, ry_s;
    logic                 cyc_r, busy_r, done_r;
    logic [1:0]           status_r;
    logic [ADDRBITS-1:0]  adr_r;
    logic [DATABITS-1:0]  dat_r;
    logic                 accept;
    logic                 tmo_hit;

    // Command word (address, data) for write number idx of a sequence.
    function automatic logic [CMD_W-1:0] cmd_word(input logic [1:0]          op,
                                                  input logic [2:0]          i,
                                                  input logic [ADDRBITS-1:0] addr,
                                                  input logic [DATABITS-1:0] data);
        logic [ADDRBITS-1:0] a;
        logic [DATABITS-1:0] d;
        a = ADDRBITS'(12'h555);
        d = DATABITS'(8'hAA);
        case (i)
            3'd0: ;
            3'd1: begin a = ADDRBITS'(12'h2AA); d = DATABITS'(8'h55); end
            3'd2: d = (op == OP_PROG) ? DATABITS'(8'hA0) : DATABITS'(8'h80);
            3'd3: if (op == OP_PROG) begin a = addr; d = data; end
            3'd4: begin a = ADDRBITS'(12'h2AA); d = DATABITS'(8'h55); end
            default: begin
                if (op == OP_SECT) begin a = addr; d = DATABITS'(8'h30); end
                else               d = DATABITS'(8'h10);
            end
        endcase
        if (op == OP_RST) begin
            a = '0;
            d = DATABITS'(8'hF0);
        end
        return {a, d};
    endfunction

    function automatic logic [2:0] last_idx(input logic [1:0] op);
        case (op)
            OP_PROG: return 3'd3;
            OP_RST:  return 3'd0;
            default: return 3'd5;
        endcase
    endfunction

    function automatic logic [TIMEOUT_W-1:0] sat_inc(input logic [TIMEOUT_W-1:0] v);
        return (&v) ? v : v + TIMEOUT_W'(1);
    endfunction

    assign accept  = (state == S_IDLE) && ry_s && bus.req_valid_i;
    assign tmo_hit = (bus.cfg_timeout_i != '0) && (tcnt == bus.cfg_timeout_i);

    // ---- RY/BY# synchroniser: ry_p0 -> ry_s ----
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            ry_p0 <= 1'b0;
            ry_s  <= 1'b0;
        end else begin
            ry_p0 <= bus.nor_ry_i;
            ry_s  <= ry_p0;
        end
    end

    // Request payload is only ever read after acceptance, so it needs no reset.
    always_ff @(posedge clk_i) begin
        if (accept) begin
            op_r   <= bus.req_op_i;
            addr_r <= bus.req_addr_i;
            data_r <= bus.req_data_i;
        end
    end

    // ---- sequencer FSM ----
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            state    <= S_IDLE;
            idx      <= '0;
            abort    <= 1'b0;
            tcnt     <= '0;
            bcnt     <= '0;
            cyc_r    <= 1'b0;
            busy_r   <= 1'b0;
            done_r   <= 1'b0;
            status_r <= 2'b00;
            adr_r    <= '0;
            dat_r    <= '0;
        end else begin
            done_r <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        idx            <= '0;
                        abort          <= 1'b0;
                        status_r       <= 2'b00;
                        busy_r         <= 1'b1;
                        {adr_r, dat_r} <= cmd_word(bus.req_op_i, 3'd0, bus.req_addr_i, bus.req_data_i);
                        cyc_r          <= 1'b1;
                        state          <= S_WR;
                    end
                end
                S_WR: begin
                    if (bus.wb_ack_i) begin
                        cyc_r <= 1'b0;
                        if (abort || op_r == OP_RST) begin
                            state    <= S_DONE;
                            done_r   <= 1'b1;
                            status_r <= abort ? 2'b01 : 2'b00;
                        end else if (idx == last_idx(op_r)) begin
                            state <= S_BLANK;
                            bcnt  <= '0;
                            tcnt  <= '0;
                        end else begin
                            idx   <= idx + 3'd1;
                            state <= S_GAP;
                        end
                    end
                end
                S_GAP: begin
                    {adr_r, dat_r} <= cmd_word(op_r, idx, addr_r, data_r);
                    cyc_r          <= 1'b1;
                    state          <= S_WR;
                end
                S_BLANK, S_POLL: begin
                    // Ready beats a coincident timeout.
                    if (state == S_POLL && ry_s) begin
                        state    <= S_DONE;
                        done_r   <= 1'b1;
                        status_r <= 2'b00;
                    end else if (tmo_hit) begin
                        abort          <= 1'b1;
                        {adr_r, dat_r} <= cmd_word(OP_RST, 3'd0, '0, '0);
                        cyc_r          <= 1'b1;
                        state          <= S_WR;
                    end else begin
                        tcnt <= sat_inc(tcnt);
                        if (state == S_BLANK) begin
                            if (bcnt == BLANK_W'(BLANK_CYC - 1)) state <= S_POLL;
                            else                                 bcnt  <= bcnt + BLANK_W'(1);
                        end
                    end
                end
                S_DONE: begin
                    busy_r <= 1'b0;
                    state  <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign bus.req_ready_o = (state == S_IDLE) && ry_s;
    assign bus.busy_o      = busy_r;
    assign bus.done_o      = done_r;
    assign bus.status_o    = status_r;
    assign bus.wb_cyc_o    = cyc_r;
    assign bus.wb_stb_o    = cyc_r;
    assign bus.wb_we_o     = cyc_r;
    assign bus.wb_adr_o    = adr_r;
    assign bus.wb_dat_o    = dat_r;
endmodule

// File: tb/tb_nor_cmd_sequencer.sv
// Directed bench for nor_cmd_sequencer: a Wishbone responder records each acked write,
// and one task per scenario compares against hand-computed command sequences and timings.
module tb_nor_cmd_sequencer;
    localparam int AB = 26;
    localparam int DB = 16;
    localparam int TW = 24;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    nor_cmd_sequencer_if #(.ADDRBITS(AB), .DATABITS(DB), .TIMEOUT_W(TW)) bus ();

    nor_cmd_sequencer #(.ADDRBITS(AB), .DATABITS(DB), .TIMEOUT_W(TW), .BLANK_CYC(4)) dut (
        .clk_i    (clk),
        .reset_ni (rst_n),
        .bus      (bus)
    );

    int total = 0;
    int bad   = 0;

    logic [AB-1:0] log_adr[$];
    logic [DB-1:0] log_dat[$];
    int            log_gap[$];
    int            log_stall[$];
    int            viol = 0;
    int            stall_idx = -1;
    int            stall_len = 0;

    // Wishbone slave model: acks after a programmable stall, logs writes and idle gaps.
    initial begin : responder
        logic          in_wr;
        logic          ack_prev;
        int            waitc;
        int            gapc;
        logic [AB-1:0] hold_a;
        logic [DB-1:0] hold_d;
        in_wr = 1'b0;
        waitc = 0;
        gapc  = 0;
        hold_a = '0;
        hold_d = '0;
        bus.wb_ack_i = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                bus.wb_ack_i = 1'b0;
                in_wr = 1'b0;
                waitc = 0;
            end else begin
                ack_prev = bus.wb_ack_i;
                bus.wb_ack_i = 1'b0;
                if (bus.wb_stb_o && !ack_prev) begin
                    if (!in_wr) begin
                        in_wr  = 1'b1;
                        hold_a = bus.wb_adr_o;
                        hold_d = bus.wb_dat_o;
                        waitc  = 0;
                        log_gap.push_back(gapc);
                    end else if (bus.wb_adr_o !== hold_a || bus.wb_dat_o !== hold_d) begin
                        viol++;
                    end
                    if (bus.wb_we_o !== 1'b1 || bus.wb_cyc_o !== 1'b1) viol++;
                    if (waitc == ((log_adr.size() == stall_idx) ? stall_len : 0)) begin
                        bus.wb_ack_i = 1'b1;
                        log_adr.push_back(hold_a);
                        log_dat.push_back(hold_d);
                        log_stall.push_back(waitc);
                        in_wr = 1'b0;
                        gapc  = 0;
                    end else begin
                        waitc++;
                    end
                end else if (!bus.wb_stb_o) begin
                    gapc++;
                end
            end
        end
    end

    task automatic clear_log();
        log_adr.delete();
        log_dat.delete();
        log_gap.delete();
        log_stall.delete();
        viol = 0;
    endtask

    task automatic issue(input logic [1:0] op, input logic [AB-1:0] a, input logic [DB-1:0] d,
                         output bit ok);
        ok = 1'b0;
        bus.req_op_i    = op;
        bus.req_addr_i  = a;
        bus.req_data_i  = d;
        bus.req_valid_i = 1'b1;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (bus.req_ready_o) begin
                ok = 1'b1;
                break;
            end
        end
        @(posedge clk);
        #1;
        bus.req_valid_i = 1'b0;
        bus.req_addr_i  = '1;
        bus.req_data_i  = '0;
        bus.req_op_i    = 2'b10;
    endtask

    task automatic wait_done(input int max, output int cyc);
        cyc = -1;
        for (int i = 1; i <= max; i++) begin
            @(posedge clk);
            #1;
            if (bus.done_o) begin
                cyc = i;
                break;
            end
        end
    endtask

    task automatic wait_writes(input int n, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 300; i++) begin
            @(posedge clk);
            #1;
            if (log_adr.size() == n) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bus.nor_ry_i = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        total++;
        if ({bus.req_ready_o, bus.busy_o, bus.done_o, bus.status_o, bus.wb_cyc_o, bus.wb_stb_o, bus.wb_we_o} !== 8'h00) begin
            bad++;
            $display("FAIL reset_ctrl got=%b exp=00000000",
                     {bus.req_ready_o, bus.busy_o, bus.done_o, bus.status_o, bus.wb_cyc_o, bus.wb_stb_o, bus.wb_we_o});
        end
        total++;
        if (bus.wb_adr_o !== '0 || bus.wb_dat_o !== '0) begin
            bad++;
            $display("FAIL reset_bus got=%h/%h exp=0/0", bus.wb_adr_o, bus.wb_dat_o);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        total++;
        if (bus.req_ready_o !== 1'b0) begin
            bad++;
            $display("FAIL reset_ready_sync1 got=%b exp=0", bus.req_ready_o);
        end
        @(posedge clk);
        #1;
        total++;
        if (bus.req_ready_o !== 1'b1) begin
            bad++;
            $display("FAIL reset_ready_sync2 got=%b exp=1", bus.req_ready_o);
        end
    endtask

    task automatic test_program();
        logic [AB-1:0] ea[4];
        logic [DB-1:0] ed[4];
        bit ok;
        int c;
        ea = '{26'h555, 26'h2AA, 26'h555, 26'h12345};
        ed = '{16'h00AA, 16'h0055, 16'h00A0, 16'hBEEF};
        clear_log();
        bus.cfg_timeout_i = '0;
        issue(2'b00, 26'h12345, 16'hBEEF, ok);
        total++;
        if (!ok) begin bad++; $display("FAIL prog_accept got=0 exp=1"); end
        wait_done(100, c);
        total++;
        if (c != 12) begin bad++; $display("FAIL prog_latency got=%0d exp=12", c); end
        total++;
        if (bus.status_o !== 2'b00 || bus.busy_o !== 1'b1) begin
            bad++;
            $display("FAIL prog_done_flags got=status%b busy%b exp=status00 busy1", bus.status_o, bus.busy_o);
        end
        total++;
        if (log_adr.size() != 4) begin
            bad++;
            $display("FAIL prog_nwrites got=%0d exp=4", log_adr.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                total++;
                if (log_adr[i] !== ea[i] || log_dat[i] !== ed[i]) begin
                    bad++;
                    $display("FAIL prog_write%0d got=%h/%h exp=%h/%h", i, log_adr[i], log_dat[i], ea[i], ed[i]);
                end
            end
            for (int i = 1; i < 4; i++) begin
                total++;
                if (log_gap[i] != 1) begin bad++; $display("FAIL prog_gap%0d got=%0d exp=1", i, log_gap[i]); end
            end
        end
        @(posedge clk);
        #1;
        total++;
        if (bus.busy_o !== 1'b0 || bus.done_o !== 1'b0) begin
            bad++;
            $display("FAIL prog_after_done got=busy%b done%b exp=busy0 done0", bus.busy_o, bus.done_o);
        end
    endtask

    task automatic test_sector_erase();
        bit ok;
        int c;
        int early;
        clear_log();
        bus.cfg_timeout_i = '0;
        bus.nor_ry_i = 1'b1;
        issue(2'b01, 26'h200000, 16'h0000, ok);
        wait_writes(6, ok);
        total++;
        if (!ok) begin bad++; $display("FAIL sect_writes got=%0d exp=6", log_adr.size()); end
        bus.nor_ry_i = 1'b0;
        early = 0;
        for (int i = 0; i < 100; i++) begin
            @(posedge clk);
            #1;
            if (bus.done_o) early++;
        end
        total++;
        if (early != 0) begin bad++; $display("FAIL sect_early_done got=%0d exp=0", early); end
        bus.nor_ry_i = 1'b1;
        wait_done(20, c);
        total++;
        if (c != 3) begin bad++; $display("FAIL sect_ry_to_done got=%0d exp=3", c); end
        total++;
        if (bus.status_o !== 2'b00) begin bad++; $display("FAIL sect_status got=%b exp=00", bus.status_o); end
        total++;
        if (log_adr.size() != 6 || log_adr[5] !== 26'h200000 || log_dat[5] !== 16'h0030 ||
            log_adr[2] !== 26'h555 || log_dat[2] !== 16'h0080) begin
            bad++;
            $display("FAIL sect_seq got=n%0d last=%h/%h exp=n6 last=200000/0030",
                     log_adr.size(), log_adr[log_adr.size()-1], log_dat[log_dat.size()-1]);
        end
    endtask

    task automatic test_chip_timeout();
        bit ok;
        int c;
        clear_log();
        bus.cfg_timeout_i = 24'd50;
        bus.nor_ry_i = 1'b1;
        issue(2'b10, 26'h3ABCDE, 16'h1111, ok);
        wait_writes(6, ok);
        total++;
        if (!ok) begin bad++; $display("FAIL chip_writes got=%0d exp=6", log_adr.size()); end
        bus.nor_ry_i = 1'b0;
        wait_done(200, c);
        total++;
        if (c != 52) begin bad++; $display("FAIL chip_timeout_latency got=%0d exp=52", c); end
        total++;
        if (bus.status_o !== 2'b01) begin bad++; $display("FAIL chip_status got=%b exp=01", bus.status_o); end
        total++;
        if (log_adr.size() != 7 || log_adr[5] !== 26'h555 || log_dat[5] !== 16'h0010 ||
            log_adr[6] !== 26'h0 || log_dat[6] !== 16'h00F0) begin
            bad++;
            $display("FAIL chip_seq got=n%0d last=%h/%h exp=n7 last=0000000/00f0",
                     log_adr.size(), log_adr[log_adr.size()-1], log_dat[log_dat.size()-1]);
        end
        bus.nor_ry_i = 1'b1;
        bus.cfg_timeout_i = '0;
        repeat (4) @(posedge clk);
        #1;
    endtask

    task automatic test_ry_block();
        int c;
        int seen;
        clear_log();
        bus.nor_ry_i = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        bus.req_op_i    = 2'b00;
        bus.req_addr_i  = 26'h00ABC;
        bus.req_data_i  = 16'h1234;
        bus.req_valid_i = 1'b1;
        seen = 0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            if (bus.req_ready_o || bus.wb_cyc_o) seen++;
        end
        total++;
        if (seen != 0) begin bad++; $display("FAIL ryblk_activity got=%0d exp=0", seen); end
        @(negedge clk);
        bus.nor_ry_i = 1'b1;
        @(posedge clk);
        #1;
        total++;
        if (bus.req_ready_o !== 1'b0) begin bad++; $display("FAIL ryblk_sync1 got=%b exp=0", bus.req_ready_o); end
        @(posedge clk);
        #1;
        total++;
        if (bus.req_ready_o !== 1'b1 || bus.wb_cyc_o !== 1'b0) begin
            bad++;
            $display("FAIL ryblk_sync2 got=ready%b cyc%b exp=ready1 cyc0", bus.req_ready_o, bus.wb_cyc_o);
        end
        @(posedge clk);
        #1;
        total++;
        if (bus.wb_cyc_o !== 1'b1 || bus.busy_o !== 1'b1) begin
            bad++;
            $display("FAIL ryblk_accept got=cyc%b busy%b exp=cyc1 busy1", bus.wb_cyc_o, bus.busy_o);
        end
        bus.req_valid_i = 1'b0;
        wait_done(100, c);
        total++;
        if (c != 12 || log_adr.size() != 4 || log_adr[3] !== 26'h00ABC || log_dat[3] !== 16'h1234) begin
            bad++;
            $display("FAIL ryblk_prog got=lat%0d n%0d exp=lat12 n4 last=0000abc/1234", c, log_adr.size());
        end
    endtask

    task automatic test_ack_stall();
        bit ok;
        int c;
        clear_log();
        stall_idx = 1;
        stall_len = 7;
        issue(2'b00, 26'h30F0F, 16'h5A5A, ok);
        wait_done(200, c);
        stall_idx = -1;
        total++;
        if (c != 19) begin bad++; $display("FAIL stall_latency got=%0d exp=19", c); end
        total++;
        if (viol != 0) begin bad++; $display("FAIL stall_stable got=%0d exp=0", viol); end
        total++;
        if (log_adr.size() != 4) begin
            bad++;
            $display("FAIL stall_nwrites got=%0d exp=4", log_adr.size());
        end else begin
            total++;
            if (log_stall[1] != 7) begin bad++; $display("FAIL stall_len got=%0d exp=7", log_stall[1]); end
            total++;
            if (log_gap[1] != 1 || log_gap[2] != 1 || log_gap[3] != 1) begin
                bad++;
                $display("FAIL stall_gaps got=%0d,%0d,%0d exp=1,1,1", log_gap[1], log_gap[2], log_gap[3]);
            end
            total++;
            if (log_adr[1] !== 26'h2AA || log_dat[1] !== 16'h0055 || log_adr[3] !== 26'h30F0F || log_dat[3] !== 16'h5A5A) begin
                bad++;
                $display("FAIL stall_seq got=%h/%h %h/%h exp=00002aa/0055 0030f0f/5a5a",
                         log_adr[1], log_dat[1], log_adr[3], log_dat[3]);
            end
        end
    endtask

    task automatic test_async_reset();
        bit ok;
        bit found;
        clear_log();
        stall_idx = 2;
        stall_len = 20;
        issue(2'b01, 26'h001000, 16'h0000, ok);
        found = 1'b0;
        for (int i = 0; i < 60; i++) begin
            @(posedge clk);
            #1;
            if (log_adr.size() == 2 && bus.wb_stb_o) begin
                found = 1'b1;
                break;
            end
        end
        total++;
        if (!found || bus.busy_o !== 1'b1) begin
            bad++;
            $display("FAIL arst_reach_wr3 got=found%0d busy%b exp=found1 busy1", found, bus.busy_o);
        end
        #2;
        rst_n = 1'b0;
        #1;
        total++;
        if ({bus.wb_cyc_o, bus.wb_stb_o, bus.busy_o} !== 3'b000) begin
            bad++;
            $display("FAIL arst_drop got=%b exp=000", {bus.wb_cyc_o, bus.wb_stb_o, bus.busy_o});
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        stall_idx = -1;
        repeat (3) @(posedge clk);
        #1;
        total++;
        if ({bus.req_ready_o, bus.busy_o, bus.wb_cyc_o, bus.status_o} !== 5'b10000) begin
            bad++;
            $display("FAIL arst_idle got=%b exp=10000", {bus.req_ready_o, bus.busy_o, bus.wb_cyc_o, bus.status_o});
        end
    endtask

    task automatic test_back_to_back();
        int d[$];
        bit rdy;
        clear_log();
        rdy = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (bus.req_ready_o) begin
                rdy = 1'b1;
                break;
            end
        end
        bus.req_op_i    = 2'b11;
        bus.req_addr_i  = 26'h1234;
        bus.req_data_i  = 16'hFFFF;
        bus.req_valid_i = 1'b1;
        for (int k = 0; k < 20; k++) begin
            @(posedge clk);
            #1;
            if (bus.done_o) d.push_back(k);
            if (d.size() == 2) break;
        end
        bus.req_valid_i = 1'b0;
        total++;
        if (!rdy || d.size() != 2) begin
            bad++;
            $display("FAIL b2b_dones got=%0d exp=2", d.size());
        end else begin
            total++;
            if (d[0] != 1 || d[1] != 4) begin
                bad++;
                $display("FAIL b2b_timing got=%0d,%0d exp=1,4", d[0], d[1]);
            end
        end
        total++;
        if (log_adr.size() != 2 || log_adr[0] !== 26'h0 || log_dat[0] !== 16'h00F0 ||
            log_adr[1] !== 26'h0 || log_dat[1] !== 16'h00F0) begin
            bad++;
            $display("FAIL b2b_writes got=n%0d exp=n2 0000000/00f0", log_adr.size());
        end
        repeat (3) @(posedge clk);
        #1;
        total++;
        if (bus.busy_o !== 1'b0 || bus.wb_cyc_o !== 1'b0) begin
            bad++;
            $display("FAIL b2b_idle got=busy%b cyc%b exp=busy0 cyc0", bus.busy_o, bus.wb_cyc_o);
        end
    endtask

    initial begin
        bus.req_valid_i   = 1'b0;
        bus.req_op_i      = 2'b00;
        bus.req_addr_i    = '0;
        bus.req_data_i    = '0;
        bus.cfg_timeout_i = '0;
        bus.nor_ry_i      = 1'b1;
        test_reset();
        test_program();
        test_sector_erase();
        test_chip_timeout();
        test_ry_block();
        test_ack_stall();
        test_async_reset();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
